gate_tester: RTL and testbench

- Sequential exhaustive-vector driver and response checker for an N-input combinational gate such as `and_gate`.
- It is the other end of the gate interface: it drives the gate inputs, waits for settling, samples the gate output, and compares it against an expected truth table.
- Instantiated beside a gate in synthesizable self-test tops. It replaces hand-written `initial`/`#10` stimulus.

---
 rtl/gate_tester_pkg.sv | 19 +
 rtl/gate_tester_settle_timer.sv | 29 ++
 rtl/gate_tester.sv | 118 +++++++++++
 tb/tb_gate_tester.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// gate_tester_pkg: shared types and constants for the gate tester.
//   state_t    - tester FSM states
//   TT_*       - expected truth tables for common 2-input gates, bit i is
//                the output for input vector i ({a,b} == i)
package gate_tester_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_tester_settle_timer.sv
// settle_timer: counts cycles a vector has been held on the gate inputs.
//   clk, rst - clock, async active-high reset
//   load     - clear the count (held whenever the tester is not settling)
//   en       - advance the count by one
//   expire   - count has reached SETTLE-1 (last settle cycle)
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 4'd1;
    end

    assign expire = (cnt == 4'(SETTLE - 1));

endmodule

// File: rtl/gate_tester.sv
// gate_tester: exhaustive vector driver and response checker for an
// N_IN-input combinational gate.
//   clk, rst   - clock, async active-high reset
//   start      - begin a run (accepted only when idle)
//   abort      - cancel a run in progress (no done pulse)
//   exp_tt     - expected truth table, captured when start is accepted
//   y_in       - gate output
//   vec_out    - gate input vector (MSB is the first gate input)
//   busy       - run in progress, including the done cycle
//   done       - one-cycle completion pulse
//   pass       - no mismatches; valid from done until next start
//   obs_tt     - observed truth table
//   fail_mask  - per-vector mismatch flags
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   exp_tt,
    input  logic                   y_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   obs_tt,
    output logic [(1<<N_IN)-1:0]   fail_mask
);

    localparam int NV = 1 << N_IN;
    localparam int IW = N_IN + 1;

    state_t          state, nxt;
    logic [IW-1:0]   idx;
    logic [NV-1:0]   exp_q;
    logic [NV-1:0]   fail_upd;
    logic            expire;
    logic            last;
    logic            accept;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state != S_SETTLE),
        .en     (state == S_SETTLE),
        .expire (expire)
    );

    assign last   = (idx == IW'(NV - 1));
    assign accept = (state == S_IDLE) && start && !abort;

    // fail_mask as it will look after this cycle's sample, so pass can be
    // registered in the same edge and be valid during the done pulse.
    always_comb begin
        fail_upd = fail_mask;
        fail_upd[idx[N_IN-1:0]] = y_in ^ exp_q[idx[N_IN-1:0]];
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (accept) nxt = S_SETTLE;
            S_SETTLE: if (abort) nxt = S_IDLE;
                      else if (expire) nxt = S_SAMPLE;
            S_SAMPLE: if (abort) nxt = S_IDLE;
                      else if (last) nxt = S_DONE;
                      else nxt = S_SETTLE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Outputs decode from state so an async reset clears them at once.
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign vec_out = (state == S_SETTLE || state == S_SAMPLE) ? idx[N_IN-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            exp_q     <= '0;
            obs_tt    <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                S_IDLE: if (accept) begin
                    exp_q     <= exp_tt;
                    obs_tt    <= '0;
                    fail_mask <= '0;
                    pass      <= 1'b0;
                    idx       <= '0;
                end
                S_SETTLE: if (abort) pass <= 1'b0;
                S_SAMPLE: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        obs_tt[idx[N_IN-1:0]] <= y_in;
                        fail_mask             <= fail_upd;
                        if (last)
                            pass <= ~|fail_upd;
                        else
                            idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tester.sv
// tb_gate_tester: directed bench for gate_tester with a behavioural gate
// (AND or OR selectable) on a default instance and an inverter on an
// N_IN=1, SETTLE=1 instance.
module tb_gate_tester;
    import gate_tester_pkg::*;

    logic       clk, rst;
    logic       start, abort;
    logic [3:0] exp_tt;
    logic       y_in;
    logic [1:0] vec_out;
    logic       busy, done, pass;
    logic [3:0] obs_tt, fail_mask;

    logic       start1, abort1;
    logic [1:0] exp1;
    logic       y1;
    logic       vec1;
    logic       busy1, done1, pass1;
    logic [1:0] obs1, fm1;

    logic       gmode;   // 0: AND gate, 1: OR gate
    int         nchk, nerr;

    gate_tester #(.N_IN(2), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tt(exp_tt),
        .y_in(y_in), .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .obs_tt(obs_tt), .fail_mask(fail_mask)
    );

    gate_tester #(.N_IN(1), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .exp_tt(exp1),
        .y_in(y1), .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .obs_tt(obs1), .fail_mask(fm1)
    );

    always_comb y_in = gmode ? (vec_out[1] | vec_out[0]) : (vec_out[1] & vec_out[0]);
    assign y1 = ~vec1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Start a run at edge 0, then observe cycles 1..20 (cycle k lies between
    // edge k-1 and edge k). abort/restart/exp change are driven in the
    // given cycle when nonzero.
    task automatic run(input logic [3:0] exp, input int abort_at, input int restart_at,
                       input int chg_at, output int done_at, output int ndone,
                       output int vec_errs, output logic [3:0] obs_d, output logic [3:0] fm_d,
                       output logic pass_d, output logic busy_d, output logic pass_c1);
        logic [1:0] exp_v;
        done_at = 0; ndone = 0; vec_errs = 0;
        obs_d = 4'hx; fm_d = 4'hx; pass_d = 1'bx; busy_d = 1'bx; pass_c1 = 1'bx;
        @(negedge clk);
        exp_tt = exp;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            abort = (k == abort_at);
            start = (k == restart_at);
            if (k == chg_at) exp_tt = 4'b1111;
            exp_v = (k <= 12 && (abort_at == 0 || k <= abort_at)) ? 2'((k - 1) / 3) : 2'd0;
            if (vec_out !== exp_v) vec_errs++;
            if (k == 1) pass_c1 = pass;
            if (done === 1'b1) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = k;
                    obs_d   = obs_tt;
                    fm_d    = fail_mask;
                    pass_d  = pass;
                    busy_d  = busy;
                end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    int         d_at, nd, verr;
    logic [3:0] o_d, f_d;
    logic       p_d, b_d, p_c1;

    initial begin
        nchk = 0; nerr = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; exp_tt = 4'h0; gmode = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; exp1 = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vec", 32'(vec_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_obs", 32'(obs_tt), 0);
        check("rst_fm", 32'(fail_mask), 0);
        @(negedge clk); rst = 1'b0;

        // AND gate, matching table
        gmode = 1'b0;
        run(TT_AND, 0, 0, 0, d_at, nd, verr, o_d, f_d, p_d, b_d, p_c1);
        check("and_done_cyc", 32'(d_at), 13);
        check("and_ndone", 32'(nd), 1);
        check("and_vec_seq", 32'(verr), 0);
        check("and_obs", 32'(o_d), 32'b1000);
        check("and_fm", 32'(f_d), 0);
        check("and_pass", 32'(p_d), 1);
        check("and_busy_done", 32'(b_d), 1);
        check("and_pass_hold", 32'(pass), 1);

        // OR gate against AND table; pass must clear on start
        gmode = 1'b1;
        run(TT_AND, 0, 0, 0, d_at, nd, verr, o_d, f_d, p_d, b_d, p_c1);
        check("or_done_cyc", 32'(d_at), 13);
        check("or_obs", 32'(o_d), 32'b1110);
        check("or_fm", 32'(f_d), 32'b0110);
        check("or_pass", 32'(p_d), 0);
        check("or_pass_clr", 32'(p_c1), 0);

        // restart ignored, exp_tt change after capture ignored
        gmode = 1'b0;
        run(TT_AND, 0, 5, 6, d_at, nd, verr, o_d, f_d, p_d, b_d, p_c1);
        check("rs_done_cyc", 32'(d_at), 13);
        check("rs_ndone", 32'(nd), 1);
        check("rs_vec_seq", 32'(verr), 0);
        check("rs_obs", 32'(o_d), 32'b1000);
        check("rs_fm", 32'(f_d), 0);
        check("rs_pass", 32'(p_d), 1);

        // abort while vector 10 settles, OR gate so partial results are visible
        gmode = 1'b1;
        run(TT_AND, 7, 0, 0, d_at, nd, verr, o_d, f_d, p_d, b_d, p_c1);
        check("ab_ndone", 32'(nd), 0);
        check("ab_vec_seq", 32'(verr), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_pass", 32'(pass), 0);
        check("ab_obs", 32'(obs_tt), 32'b0010);
        check("ab_fm", 32'(fail_mask), 32'b0010);

        // async reset in the middle of the SAMPLE cycle for vector 10
        gmode = 1'b1;
        @(negedge clk);
        exp_tt = TT_AND; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        check("rr_pre_vec", 32'(vec_out), 2);
        check("rr_pre_busy", 32'(busy), 1);
        check("rr_pre_obs", 32'(obs_tt), 32'b0010);
        rst = 1'b1;
        #1;
        check("rr_vec", 32'(vec_out), 0);
        check("rr_busy", 32'(busy), 0);
        check("rr_done", 32'(done), 0);
        check("rr_obs", 32'(obs_tt), 0);
        check("rr_fm", 32'(fail_mask), 0);
        @(negedge clk); rst = 1'b0;
        gmode = 1'b0;
        run(TT_AND, 0, 0, 0, d_at, nd, verr, o_d, f_d, p_d, b_d, p_c1);
        check("rr_done_cyc", 32'(d_at), 13);
        check("rr_vec_seq", 32'(verr), 0);
        check("rr_obs2", 32'(o_d), 32'b1000);
        check("rr_pass2", 32'(p_d), 1);

        // N_IN=1, SETTLE=1, inverter
        begin
            int d1 = 0, n1 = 0, v1 = 0;
            logic [1:0] o1 = 2'bxx, f1 = 2'bxx;
            logic p1 = 1'bx;
            @(negedge clk);
            exp1 = 2'b01; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                if (vec1 !== ((k >= 3 && k <= 4) ? 1'b1 : 1'b0)) v1++;
                if (done1 === 1'b1) begin
                    n1++;
                    if (d1 == 0) begin d1 = k; o1 = obs1; f1 = fm1; p1 = pass1; end
                end
                @(posedge clk); #1;
            end
            check("inv_done_cyc", 32'(d1), 5);
            check("inv_ndone", 32'(n1), 1);
            check("inv_vec_seq", 32'(v1), 0);
            check("inv_obs", 32'(o1), 32'b01);
            check("inv_fm", 32'(f1), 0);
            check("inv_pass", 32'(p1), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
